// File: rtl/bpf_capture.sv
// Capture FIFO behind a band-pass filter: decimates valid samples, buffers them for a reader,
// flags drops, and optionally tracks the peak sample (define BPF_CAPTURE_PEAK_EN).
module bpf_capture #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8,
   parameter int DECIM = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           din,
   input  logic                       din_valid,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           dout,
   output logic                       dout_valid,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   input  logic                       ovf_clr,
   output logic [WIDTH-1:0]           peak,
   input  logic                       peak_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [7:0]    DEC_LAST = 8'(DECIM - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [7:0]       dec_cnt;
   logic [CW-1:0]    count_nxt;
   logic             accept, do_wr, do_rd, drop;

   // A write into a full FIFO is allowed when a read frees the slot in the same cycle.
   always_comb begin
      accept    = din_valid & (dec_cnt == 8'd0);
      do_rd     = rd_en & ~empty;
      do_wr     = accept & (~full | do_rd);
      drop      = accept & full & ~do_rd;
      count_nxt = count;
      case ({do_wr, do_rd})
         2'b10:   count_nxt = count + CNT_ONE;
         2'b01:   count_nxt = count - CNT_ONE;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         dec_cnt    <= '0;
         count      <= '0;
         empty      <= 1'b1;
         full       <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (din_valid)
            dec_cnt <= (dec_cnt == DEC_LAST) ? 8'd0 : dec_cnt + 8'd1;
         if (do_wr)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (do_rd) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            dout   <= mem[rd_ptr];
         end
         dout_valid <= do_rd;
         count      <= count_nxt;
         empty      <= (count_nxt == '0);
         full       <= (count_nxt == CNT_FULL);
         if (drop)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;
      end
   end

   // Storage carries no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (rst && do_wr)
         mem[wr_ptr] <= din;
   end

`ifdef BPF_CAPTURE_PEAK_EN
   always_ff @(posedge clk) begin
      if (!rst)
         peak <= '0;
      else if (peak_clr)
         peak <= accept ? din : '0;
      else if (accept && (din > peak))
         peak <= din;
   end
`else
   logic unused_peak_clr;
   assign unused_peak_clr = peak_clr;
   assign peak            = '0;
`endif

endmodule

// File: tb/tb_bpf_capture.sv
// Directed bench for bpf_capture: queue scoreboard for a DECIM=1 instance plus a DECIM=3 instance.
module tb_bpf_capture;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] din, dout, peak;
   logic       din_valid, rd_en, ovf_clr, peak_clr;
   logic       dout_valid, empty, full, overflow;
   logic [3:0] count;

   logic [9:0] din1, dout1, peak1;
   logic       dv1, rd1, dvo1, empty1, full1, ovf1;
   logic [3:0] count1;

   int total = 0;
   int bad   = 0;

   logic [9:0] q[$];
   logic [9:0] q1[$];
   logic [9:0] m_dout, m_peak, m_dout1, m_peak1;
   logic       m_dv, m_ovf, m_dv1;
   int         m_dc1;

   always #5 clk = ~clk;

   bpf_capture #(.WIDTH(10), .DEPTH(8), .DECIM(1)) u0 (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .rd_en(rd_en),
      .dout(dout), .dout_valid(dout_valid), .empty(empty), .full(full), .count(count),
      .overflow(overflow), .ovf_clr(ovf_clr), .peak(peak), .peak_clr(peak_clr)
   );

   bpf_capture #(.WIDTH(10), .DEPTH(8), .DECIM(3)) u1 (
      .clk(clk), .rst(rst), .din(din1), .din_valid(dv1), .rd_en(rd1),
      .dout(dout1), .dout_valid(dvo1), .empty(empty1), .full(full1), .count(count1),
      .overflow(ovf1), .ovf_clr(1'b0), .peak(peak1), .peak_clr(1'b0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(m_dv));
      chk({tag, ".dout"},       32'(dout),       32'(m_dout));
      chk({tag, ".count"},      32'(count),      32'(q.size()));
      chk({tag, ".empty"},      32'(empty),      32'(q.size() == 0));
      chk({tag, ".full"},       32'(full),       32'(q.size() == 8));
      chk({tag, ".overflow"},   32'(overflow),   32'(m_ovf));
      chk({tag, ".peak"},       32'(peak),       32'(m_peak));
   endtask

   task automatic check_all1(input string tag);
      chk({tag, ".dout_valid"}, 32'(dvo1),     32'(m_dv1));
      chk({tag, ".dout"},       32'(dout1),    32'(m_dout1));
      chk({tag, ".count"},      32'(count1),   32'(q1.size()));
      chk({tag, ".empty"},      32'(empty1),   32'(q1.size() == 0));
      chk({tag, ".full"},       32'(full1),    32'(q1.size() == 8));
      chk({tag, ".overflow"},   32'(ovf1),     32'(0));
      chk({tag, ".peak"},       32'(peak1),    32'(m_peak1));
   endtask

   // One cycle on u0: update the scoreboard from the pre-edge state, clock, then compare.
   task automatic cyc(input string tag, input logic [9:0] d, input logic v, input logic r,
                      input logic oc, input logic pc);
      int  n;
      logic rd_ok, drop;
      din = d; din_valid = v; rd_en = r; ovf_clr = oc; peak_clr = pc;
      n     = q.size();
      rd_ok = r && (n > 0);
      drop  = v && (n == 8) && !rd_ok;
      m_dv  = rd_ok;
      if (rd_ok) m_dout = q.pop_front();
      if (v && !drop) q.push_back(d);
      if (drop) m_ovf = 1'b1;
      else if (oc) m_ovf = 1'b0;
`ifdef BPF_CAPTURE_PEAK_EN
      if (pc) m_peak = v ? d : 10'd0;
      else if (v && d > m_peak) m_peak = d;
`endif
      @(posedge clk); #1;
      din_valid = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; peak_clr = 1'b0;
      check_all(tag);
   endtask

   task automatic cyc1(input string tag, input logic [9:0] d, input logic v, input logic r);
      logic acc, rd_ok;
      din1 = d; dv1 = v; rd1 = r;
      acc   = v && (m_dc1 == 0);
      rd_ok = r && (q1.size() > 0);
      if (v) m_dc1 = (m_dc1 == 2) ? 0 : m_dc1 + 1;
      m_dv1 = rd_ok;
      if (rd_ok) m_dout1 = q1.pop_front();
      if (acc) q1.push_back(d);
`ifdef BPF_CAPTURE_PEAK_EN
      if (acc && d > m_peak1) m_peak1 = d;
`endif
      @(posedge clk); #1;
      dv1 = 1'b0; rd1 = 1'b0;
      check_all1(tag);
   endtask

   task automatic model_reset();
      q.delete(); q1.delete();
      m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_peak = '0;
      m_dout1 = '0; m_dv1 = 1'b0; m_peak1 = '0; m_dc1 = 0;
   endtask

   initial begin
      rst = 1'b0; din = '0; din_valid = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; peak_clr = 1'b0;
      din1 = '0; dv1 = 1'b0; rd1 = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      check_all1("reset1");
      rst = 1'b1;

      // basic ordering
      cyc("wr5",  10'd5,  1, 0, 0, 0);
      cyc("wr10", 10'd10, 1, 0, 0, 0);
      cyc("wr12", 10'd12, 1, 0, 0, 0);
      cyc("wr15", 10'd15, 1, 0, 0, 0);
      cyc("wr16", 10'd16, 1, 0, 0, 0);
      repeat (5) cyc("rd_basic", '0, 0, 1, 0, 0);
      cyc("idle_empty", '0, 0, 0, 0, 0);

      // fill past full, drop sets overflow
      for (int i = 1; i <= 9; i++) cyc("fill", 10'(i), 1, 0, 0, 0);
      cyc("drop_vs_clr", 10'd200, 1, 0, 1, 0);
      cyc("ovf_clr", '0, 0, 0, 1, 0);
      cyc("full_rw", 10'd100, 1, 1, 0, 0);
      repeat (8) cyc("drain", '0, 0, 1, 0, 0);
      cyc("rd_empty", '0, 0, 1, 0, 0);

      // read while empty with simultaneous write: no fall-through
      cyc("rd_empty_wr42", 10'd42, 1, 1, 0, 0);
      cyc("rd42", '0, 0, 1, 0, 0);

      // peak tracking and clear
      cyc("pk300",  10'd300,  1, 0, 0, 0);
      cyc("pk1023", 10'd1023, 1, 0, 0, 0);
      cyc("pk7",    10'd7,    1, 0, 0, 0);
      cyc("pkclr9", 10'd9,    1, 0, 0, 1);
      cyc("pkclr",  '0,       0, 0, 0, 1);
      cyc("pk11",   10'd11,   1, 1, 0, 0);

      // decimation by 3 on the second instance
      for (int i = 1; i <= 9; i++) cyc1("dec_wr", 10'(i), 1, 0);
      repeat (4) cyc1("dec_rd", '0, 0, 1);
      cyc1("dec_wr10", 10'd10, 1, 0);

      // mid-stream reset with active inputs
      rst = 1'b0; din = 10'd55; din_valid = 1'b1; rd_en = 1'b1;
      din1 = 10'd55; dv1 = 1'b1; rd1 = 1'b1;
      @(posedge clk); #1;
      din_valid = 1'b0; rd_en = 1'b0; dv1 = 1'b0; rd1 = 1'b0;
      model_reset();
      check_all("mid_reset");
      check_all1("mid_reset1");
      rst = 1'b1;
      cyc("post_wr77", 10'd77, 1, 0, 0, 0);
      cyc("post_rd77", '0, 0, 1, 0, 0);
      cyc1("post_dec_wr", 10'd3, 1, 0);
      cyc1("post_dec_rd", '0, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
